// File: rtl/mkio_rt_sched_if.sv
// Word-level link between the MKIO RT scheduler and its Manchester decoder/encoder.
interface mkio_rt_sched_if;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_cd;
    logic        p_error;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic        tx_busy;

    // master: decoder/encoder side; slave: the scheduler
    modport master (
        output rx_data, rx_valid, rx_cd, p_error, tx_busy,
        input  tx_data, tx_cd, tx_ready
    );
    modport slave (
        input  rx_data, rx_valid, rx_cd, p_error, tx_busy,
        output tx_data, tx_cd, tx_ready
    );
endinterface

// File: rtl/mkio_rt_sched.sv
// MKIO remote-terminal command scheduler: decodes commands, starts per-subaddress channels, owns the TX mux.
// Optional statistics (illegal_cnt, perr_cnt, err_timeout) are built only when MKIO_SCHED_STAT_EN is defined.
module mkio_rt_sched #(
    parameter logic [4:0]  ADDRESS = 5'd1,
    parameter int unsigned NUM_SA  = 4,
    parameter logic [4:0]  SA_BASE = 5'd1,
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic                   clk,
    input  logic                   reset,
    mkio_rt_sched_if.slave         bus,
    output logic [15:0]            cmd_word,
    output logic [NUM_SA-1:0]      dev_start,
    input  logic [NUM_SA-1:0]      dev_busy,
    input  logic [16*NUM_SA-1:0]   dev_tx_data,
    input  logic [NUM_SA-1:0]      dev_tx_cd,
    input  logic [NUM_SA-1:0]      dev_tx_ready,
    output logic [NUM_SA-1:0]      dev_tx_busy,
    output logic                   sched_busy,
    output logic                   done,
    output logic                   err_timeout,
    output logic [7:0]             illegal_cnt,
    output logic [7:0]             perr_cnt
);
    localparam int unsigned SEL_W   = (NUM_SA > 1) ? $clog2(NUM_SA) : 1;
    localparam logic [4:0]  NUM_SA5 = 5'(NUM_SA);
    localparam logic [15:0] ACK_MAX = 16'd3;

    typedef enum logic [2:0] {ST_IDLE, ST_DISPATCH, ST_WAIT_ACK, ST_ACTIVE, ST_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [NUM_SA-1:0]  start_q, start_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [15:0]        tx_data_q, tx_data_d;
    logic               tx_cd_q, tx_cd_d;
    logic               tx_ready_q, tx_ready_d;

    logic [15:0]        ch_data [NUM_SA];
    logic               addr_hit, perr_ev, legal_ev, illegal_ev, tmo_ev;
    logic [4:0]         sa_off;
    logic [SEL_W-1:0]   sel_new;

    for (genvar k = 0; k < NUM_SA; k++) begin : g_ch
        assign ch_data[k] = dev_tx_data[16*k +: 16];
    end

    // Command classification; broadcast (31) never matches a unicast address
    always_comb begin
        sa_off     = bus.rx_data[9:5] - SA_BASE;
        sel_new    = SEL_W'(sa_off);
        addr_hit   = bus.rx_valid && bus.rx_cd && (bus.rx_data[15:11] == ADDRESS)
                     && (bus.rx_data[15:11] != 5'd31);
        perr_ev    = addr_hit && bus.p_error;
        legal_ev   = addr_hit && !bus.p_error && bus.rx_data[10]
                     && (bus.rx_data[9:5] >= SA_BASE) && (sa_off < NUM_SA5);
        illegal_ev = addr_hit && !bus.p_error && !legal_ev;
    end

    // Next-state logic; a legal command overrides whatever the FSM would do this cycle
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        start_d     = '0;
        done_d      = 1'b0;
        tmo_ev      = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_DISPATCH: begin
                sel_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (dev_busy[sel_q]) begin
                    cnt_d   = '0;
                    state_d = ST_ACTIVE;
                end else if (cnt_q == ACK_MAX) begin
                    tmo_ev      = 1'b1;
                    sel_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ACTIVE: begin
                if (!dev_busy[sel_q]) begin
                    state_d = ST_DRAIN;
                end else if (cnt_q == TIMEOUT) begin
                    tmo_ev      = 1'b1;
                    sel_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (!bus.tx_busy) begin
                    done_d      = 1'b1;
                    sel_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (legal_ev) begin
            cmd_d            = bus.rx_data;
            sel_d            = sel_new;
            sel_valid_d      = 1'b0;
            cnt_d            = '0;
            start_d[sel_new] = 1'b1;
            done_d           = 1'b0;
            tmo_ev           = 1'b0;
            state_d          = ST_DISPATCH;
        end

        busy_d     = (state_d != ST_IDLE);
        tx_data_d  = '0;
        tx_cd_d    = 1'b0;
        tx_ready_d = 1'b0;
        if (sel_valid_d) begin
            tx_data_d  = ch_data[sel_d];
            tx_cd_d    = dev_tx_cd[sel_d];
            tx_ready_d = dev_tx_ready[sel_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            start_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            tx_data_q   <= '0;
            tx_cd_q     <= 1'b0;
            tx_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            start_q     <= start_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            tx_data_q   <= tx_data_d;
            tx_cd_q     <= tx_cd_d;
            tx_ready_q  <= tx_ready_d;
        end
    end

    // Non-owners see a busy encoder and stall
    always_comb begin
        dev_tx_busy = '1;
        if (sel_valid_q) dev_tx_busy[sel_q] = bus.tx_busy;
    end

    assign cmd_word     = cmd_q;
    assign dev_start    = start_q;
    assign done         = done_q;
    assign sched_busy   = busy_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_cd    = tx_cd_q;
    assign bus.tx_ready = tx_ready_q;

`ifdef MKIO_SCHED_STAT_EN
    logic [7:0] illegal_q, illegal_d;
    logic [7:0] perr_q, perr_d;
    logic       err_q, err_d;

    // Saturating error statistics; sticky timeout flag cleared by the next legal command
    always_comb begin
        illegal_d = illegal_q;
        perr_d    = perr_q;
        err_d     = err_q;
        if (illegal_ev && (illegal_q != 8'hFF)) illegal_d = illegal_q + 8'd1;
        if (perr_ev && (perr_q != 8'hFF))       perr_d    = perr_q + 8'd1;
        if (tmo_ev)   err_d = 1'b1;
        if (legal_ev) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= '0;
            perr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            perr_q    <= perr_d;
            err_q     <= err_d;
        end
    end

    assign illegal_cnt = illegal_q;
    assign perr_cnt    = perr_q;
    assign err_timeout = err_q;
`else
    logic unused_stat;
    assign unused_stat = ^{illegal_ev, perr_ev, tmo_ev};
    assign illegal_cnt = '0;
    assign perr_cnt    = '0;
    assign err_timeout = 1'b0;
`endif

endmodule
